// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and types for the multi-channel timer
// Purpose: TAC field positions, divider tap table, per-channel register
//   offsets and the channel overflow FSM encoding.
// Ports: none (package).
package timer_pkg;

  localparam int TAC_EN_BIT      = 2;
  localparam int TAC_ONESHOT_BIT = 3;

  // Divider bit observed for each TAC[1:0] tap select.
  localparam int TAP_BIT_00 = 9;
  localparam int TAP_BIT_01 = 3;
  localparam int TAP_BIT_10 = 5;
  localparam int TAP_BIT_11 = 7;

  // Register offsets inside one channel's 4-byte window.
  localparam logic [1:0] OFF_TIMA = 2'd0;
  localparam logic [1:0] OFF_TMA  = 2'd1;
  localparam logic [1:0] OFF_TAC  = 2'd2;

  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_DELAY  = 2'd1,
    ST_RELOAD = 2'd2
  } ch_state_t;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one TIMA/TMA/TAC channel with delayed overflow reload
// Purpose: falling-edge counter on the selected divider tap, overflow delay
//   window, reload from TMA, optional one-shot, level interrupt.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_taps[3:0]     divider bits indexed by TAC[1:0]
//   i_din[7:0]      write data
//   i_wr_tima/tma/tac  single-clock write strobes
//   i_int_ack       interrupt acknowledge
//   o_tima, o_tma, o_tac  register contents
//   o_int_req       interrupt request, held until acknowledged
module timer_channel
  import timer_pkg::*;
#(
  parameter int OVF_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_taps,
  input  logic [7:0] i_din,
  input  logic       i_wr_tima,
  input  logic       i_wr_tma,
  input  logic       i_wr_tac,
  input  logic       i_int_ack,
  output logic [7:0] o_tima,
  output logic [7:0] o_tma,
  output logic [3:0] o_tac,
  output logic       o_int_req
);

  localparam int CNT_W = (OVF_DELAY > 1) ? $clog2(OVF_DELAY) : 1;

  logic [7:0]       r_tima;
  logic [7:0]       r_tma;
  logic [3:0]       r_tac;
  logic             r_int_req;
  logic             r_tick_prev;
  logic [CNT_W-1:0] r_cnt;
  ch_state_t        r_state;

  logic w_tick;
  logic w_fall;

  // Gating enable into the tap (rather than gating the edge) reproduces the
  // DMG glitch: dropping enable or moving the tap while high counts once.
  assign w_tick = r_tac[TAC_EN_BIT] & i_taps[r_tac[1:0]];
  assign w_fall = r_tick_prev & ~w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tima      <= '0;
      r_tma       <= '0;
      r_tac       <= '0;
      r_int_req   <= 1'b0;
      r_tick_prev <= 1'b0;
      r_cnt       <= '0;
      r_state     <= ST_COUNT;
    end else begin
      r_tick_prev <= w_tick;
      if (i_wr_tma)  r_tma     <= i_din;
      if (i_wr_tac)  r_tac     <= i_din[3:0];
      if (i_int_ack) r_int_req <= 1'b0;
      case (r_state)
        ST_COUNT: begin
          if (i_wr_tima) begin
            r_tima <= i_din;
          end else if (w_fall) begin
            if (r_tima == 8'hFF) begin
              r_tima  <= 8'h00;
              r_cnt   <= CNT_W'(OVF_DELAY - 1);
              r_state <= (OVF_DELAY == 1) ? ST_RELOAD : ST_DELAY;
            end else begin
              r_tima <= r_tima + 8'd1;
            end
          end
        end
        ST_DELAY: begin
          // A CPU write to TIMA here aborts the pending reload and interrupt.
          if (i_wr_tima) begin
            r_tima  <= i_din;
            r_state <= ST_COUNT;
          end else begin
            if (w_fall) r_tima <= r_tima + 8'd1;
            if (r_cnt == CNT_W'(1)) r_state <= ST_RELOAD;
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RELOAD: begin
          // Reload beats TIMA writes and ticks; a same-clock TMA write is
          // forwarded; set beats a same-clock acknowledge.
          r_tima    <= i_wr_tma ? i_din : r_tma;
          r_int_req <= 1'b1;
          if (r_tac[TAC_ONESHOT_BIT]) r_tac[TAC_EN_BIT] <= 1'b0;
          r_state   <= ST_COUNT;
        end
        default: r_state <= ST_COUNT;
      endcase
    end
  end

  assign o_tima    = r_tima;
  assign o_tma     = r_tma;
  assign o_tac     = r_tac;
  assign o_int_req = r_int_req;

endmodule

// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - shared divider with NCH DMG-style timer channels
// Purpose: free-running divider (DIV), bus address decode, per-channel write
//   strobes and combinational read mux.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   a[15:0]       bus address
//   din[7:0]      write data
//   rd            read strobe (dout does not depend on it)
//   wr            write strobe
//   dout[7:0]     read data, 0xFF when unmapped
//   int_req[NCH]  per-channel interrupt request
//   int_ack[NCH]  per-channel acknowledge
module timer_multi
  import timer_pkg::*;
#(
  parameter int          NCH       = 1,
  parameter int          DIV_W     = 16,
  parameter int          OVF_DELAY = 4,
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    a,
  input  logic [7:0]     din,
  input  logic           rd,
  input  logic           wr,
  output logic [7:0]     dout,
  output logic [NCH-1:0] int_req,
  input  logic [NCH-1:0] int_ack
);

  logic [DIV_W-1:0] r_div;

  logic [15:0] w_rel;
  logic [15:0] w_idx;
  logic        w_is_div;
  logic [13:0] w_ch;
  logic [1:0]  w_off;
  logic [3:0]  w_taps;
  logic        w_unused_rd;

  logic [7:0] w_tima [NCH];
  logic [7:0] w_tma  [NCH];
  logic [3:0] w_tac  [NCH];

  assign w_unused_rd = rd;

  // Channel i occupies BASE+1+4i .. BASE+4+4i; index is (a-BASE-1)/4.
  assign w_rel    = a - BASE_ADDR;
  assign w_is_div = (w_rel == 16'd0);
  assign w_idx    = w_rel - 16'd1;
  assign w_ch     = w_idx[15:2];
  assign w_off    = w_idx[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (wr && w_is_div) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_taps = {r_div[TAP_BIT_11], r_div[TAP_BIT_10], r_div[TAP_BIT_01], r_div[TAP_BIT_00]};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic w_sel;
    assign w_sel = wr && !w_is_div && (w_ch == 14'(i));

    timer_channel #(
      .OVF_DELAY(OVF_DELAY)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_taps    (w_taps),
      .i_din     (din),
      .i_wr_tima (w_sel && (w_off == OFF_TIMA)),
      .i_wr_tma  (w_sel && (w_off == OFF_TMA)),
      .i_wr_tac  (w_sel && (w_off == OFF_TAC)),
      .i_int_ack (int_ack[i]),
      .o_tima    (w_tima[i]),
      .o_tma     (w_tma[i]),
      .o_tac     (w_tac[i]),
      .o_int_req (int_req[i])
    );
  end

  always_comb begin
    dout = 8'hFF;
    if (w_is_div) begin
      dout = r_div[DIV_W-1 -: 8];
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_ch == 14'(i)) begin
          case (w_off)
            OFF_TIMA: dout = w_tima[i];
            OFF_TMA:  dout = w_tma[i];
            OFF_TAC:  dout = {4'hF, w_tac[i]};
            default:  dout = 8'hFF;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - scoreboard bench for timer_multi (NCH=2)
module tb_timer_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din;
  logic        rd;
  logic        wr;
  logic [7:0]  dout;
  logic [1:0]  int_req;
  logic [1:0]  int_ack;

  timer_multi #(
    .NCH       (2),
    .DIV_W     (16),
    .OVF_DELAY (4),
    .BASE_ADDR (16'hFF04)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .din     (din),
    .rd      (rd),
    .wr      (wr),
    .dout    (dout),
    .int_req (int_req),
    .int_ack (int_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] d;
    logic [1:0] irq;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  // Monitor: every clock with rd high presents one response to compare.
  always @(negedge clk) begin
    if (rd) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: dout=%02h with empty scoreboard", dout);
      end else begin
        m_e = sb.pop_front();
        checks++;
        if (dout !== m_e.d) begin
          errors++;
          $display("FAIL %s: dout=%02h expected %02h", m_e.name, dout, m_e.d);
        end
        checks++;
        if (int_req !== m_e.irq) begin
          errors++;
          $display("FAIL %s_irq: int_req=%b expected %b", m_e.name, int_req, m_e.irq);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
    a   = addr;
    din = data;
    wr  = 1'b1;
    rd  = 1'b0;
    step();
    wr  = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [15:0] addr,
                         input logic [7:0] d, input logic [1:0] irq);
    exp_t e;
    e.name = name;
    e.d    = d;
    e.irq  = irq;
    sb.push_back(e);
    a  = addr;
    rd = 1'b1;
    wr = 1'b0;
    step();
    rd = 1'b0;
  endtask

  // TIMA=0xFE, clear divider, enable tap div[3]; returns at cycle 1.
  task automatic setup_run();
    do_write(16'hFF05, 8'hFE);
    do_write(16'hFF04, 8'h00);
    do_write(16'hFF07, 8'h05);
  endtask

  // Expected TIMA at cycle k after setup_run with TMA=0x10.
  function automatic logic [7:0] ovf_exp(input int k);
    if (k <= 16)      return 8'hFE;
    else if (k <= 32) return 8'hFF;
    else if (k <= 36) return 8'h00;
    else              return 8'h10;
  endfunction

  initial begin
    rst = 1'b1; a = '0; din = '0; rd = 1'b0; wr = 1'b0; int_ack = '0;
    repeat (3) step();
    rst = 1'b0;

    do_read("init_div",  16'hFF04, 8'h00, 2'b00);
    do_read("init_tima", 16'hFF05, 8'h00, 2'b00);
    do_read("init_tma",  16'hFF06, 8'h00, 2'b00);
    do_read("init_tac0", 16'hFF07, 8'hF0, 2'b00);
    do_read("init_tac1", 16'hFF0B, 8'hF0, 2'b00);

    // Overflow, 4-clock zero window, reload with interrupt.
    do_write(16'hFF06, 8'h10);
    setup_run();
    for (int k = 1; k <= 40; k++)
      do_read("ovf_seq", 16'hFF05, ovf_exp(k), (k >= 37) ? 2'b01 : 2'b00);
    int_ack = 2'b01; step(); int_ack = 2'b00;
    do_read("ack_clr", 16'hFF05, 8'h10, 2'b00);
    do_write(16'hFF07, 8'h00);
    do_read("dis_pre",   16'hFF05, 8'h10, 2'b00);
    do_read("dis_glitch", 16'hFF05, 8'h11, 2'b00);
    do_read("dis_hold",  16'hFF05, 8'h11, 2'b00);

    // TIMA write on second DELAY clock cancels reload.
    setup_run();
    for (int k = 1; k <= 33; k++)
      do_read("cancel_seq", 16'hFF05, ovf_exp(k), 2'b00);
    do_write(16'hFF05, 8'h33);
    for (int k = 35; k <= 40; k++)
      do_read("cancel_hold", 16'hFF05, 8'h33, 2'b00);
    do_write(16'hFF07, 8'h00);
    do_read("cancel_pre",    16'hFF05, 8'h33, 2'b00);
    do_read("cancel_glitch", 16'hFF05, 8'h34, 2'b00);

    // DIV write while tap high: exactly one increment.
    do_write(16'hFF05, 8'h40);
    do_write(16'hFF04, 8'h00);
    do_write(16'hFF07, 8'h05);
    for (int k = 1; k <= 8; k++)
      do_read("divw_pre", 16'hFF05, 8'h40, 2'b00);
    do_write(16'hFF04, 8'h5A);
    do_read("divw_div", 16'hFF04, 8'h00, 2'b00);
    for (int k = 11; k <= 20; k++)
      do_read("divw_once", 16'hFF05, 8'h41, 2'b00);
    do_write(16'hFF07, 8'h00);
    do_read("divw_dis_pre", 16'hFF05, 8'h41, 2'b00);
    do_read("divw_dis",     16'hFF05, 8'h42, 2'b00);

    // TMA write and ack in the RELOAD clock.
    do_write(16'hFF06, 8'h10);
    setup_run();
    for (int k = 1; k <= 35; k++)
      do_read("tmaw_seq", 16'hFF05, ovf_exp(k), 2'b00);
    int_ack = 2'b01;
    do_write(16'hFF06, 8'h77);
    int_ack = 2'b00;
    do_read("tmaw_tima", 16'hFF05, 8'h77, 2'b01);
    do_read("tmaw_tma",  16'hFF06, 8'h77, 2'b01);
    int_ack = 2'b01; step(); int_ack = 2'b00;
    do_read("tmaw_ack", 16'hFF05, 8'h77, 2'b00);
    do_write(16'hFF07, 8'h00);
    do_read("tmaw_dis_pre", 16'hFF05, 8'h77, 2'b00);
    do_read("tmaw_dis",     16'hFF05, 8'h78, 2'b00);

    // Channel 1 one-shot on div[9].
    do_write(16'hFF0A, 8'h80);
    do_write(16'hFF09, 8'hFF);
    do_write(16'hFF04, 8'h00);
    do_write(16'hFF0B, 8'h0C);
    repeat (1023) step();
    do_read("os_pre", 16'hFF09, 8'hFF, 2'b00);
    for (int k = 1025; k <= 1028; k++)
      do_read("os_zero", 16'hFF09, 8'h00, 2'b00);
    do_read("os_reload", 16'hFF09, 8'h80, 2'b10);
    do_read("os_tac",    16'hFF0B, 8'hF8, 2'b10);
    repeat (2100) step();
    do_read("os_tac_late",  16'hFF0B, 8'hF8, 2'b10);
    do_read("os_tima_late", 16'hFF09, 8'h80, 2'b10);
    do_read("os_ch0_quiet", 16'hFF05, 8'h78, 2'b10);

    // Reset in the middle of DELAY.
    do_write(16'hFF06, 8'h10);
    setup_run();
    for (int k = 1; k <= 33; k++)
      do_read("rst_seq", 16'hFF05, ovf_exp(k), 2'b10);
    rst = 1'b1;
    do_read("rst_tima", 16'hFF05, 8'h00, 2'b00);
    do_read("rst_div",  16'hFF04, 8'h00, 2'b00);
    rst = 1'b0;
    do_read("post_tma0",  16'hFF06, 8'h00, 2'b00);
    do_read("post_tac0",  16'hFF07, 8'hF0, 2'b00);
    do_read("post_tima1", 16'hFF09, 8'h00, 2'b00);
    do_read("post_tma1",  16'hFF0A, 8'h00, 2'b00);
    do_read("post_tac1",  16'hFF0B, 8'hF0, 2'b00);
    do_read("map_ch0_p3", 16'hFF08, 8'hFF, 2'b00);
    do_read("map_ch1_p3", 16'hFF0C, 8'hFF, 2'b00);
    do_read("map_above",  16'hFF0D, 8'hFF, 2'b00);
    do_read("map_below",  16'hFF03, 8'hFF, 2'b00);
    do_read("post_tima0", 16'hFF05, 8'h00, 2'b00);

    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
